// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage ahead of the IF/ID register. Owns the PC and issues in-order word
// fetches to a variable-latency instruction memory. Each accepted request
// reserves a queue slot, so responses land in the order their requests went
// out. The oldest completed slot is presented to IF/ID. A taken-branch redirect
// flushes the queue. Responses still owed by the memory for flushed fetches
// are counted and discarded when they arrive.
//
// Parameters:
//   DEPTH     queue entries; also caps buffered + in-flight fetches (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, reset                      clock; asynchronous active-low reset
//   redirect, redirect_pc           taken branch from EX/MEM and its target
//   imem_req_valid/ready/addr       fetch request channel (word addresses)
//   imem_rsp_valid/data             in-order fetch responses
//   if_valid/ready, if_pc/instr     {pc, instr} toward IF/ID (if_ready low = stall)
//
// Optional feature (macro FETCH_BYPASS_EN):
//   When no completed slot sits ahead of the responding slot, a response is
//   presented on if_* in the same cycle. If if_ready is high, it is consumed
//   without being written to the queue. Without the macro, every response is
//   registered first, and there is no combinational path from imem_rsp_* to if_*.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Pointers: head = next slot to present, tail = next slot to reserve,
  // rptr = oldest reserved slot still waiting for its response.
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, rptr_q, rptr_d;
  // cnt = reserved slots (entries + outstanding); out = slots awaiting data;
  // drop = responses still owed for fetches abandoned by a redirect.
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d, last_pc_q, last_pc_d;
  logic          run_q, run_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic [63:0] slot_pc_q    [DEPTH];
  logic [31:0] slot_instr_q [DEPTH];
  logic [DEPTH-1:0] pc_we, instr_we;

  logic [CW:0] occ;
  logic        accept, pop, rsp_take, head_ready, bypass;

  // Output and handshake decode.
  always_comb begin
    // Dropped fetches still occupy the memory pipeline. Counting them here keeps
    // in-flight work bounded by DEPTH, so no counter can wrap.
    occ            = {1'b0, cnt_q} + {1'b0, drop_q};
    imem_req_valid = run_q && !redirect && (occ < DEPTH_W);
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (drop_q == '0) && (out_q != '0);
    head_ready     = (cnt_q != '0) && done_q[head_q];
`ifdef FETCH_BYPASS_EN
    bypass   = !head_ready && rsp_take && !redirect && (rptr_q == head_q);
    if_valid = head_ready || bypass;
    if_instr = head_ready ? slot_instr_q[head_q] : (bypass ? imem_rsp_data : NOP);
`else
    bypass   = 1'b0;
    if_valid = head_ready;
    if_instr = head_ready ? slot_instr_q[head_q] : NOP;
`endif
    if_pc = if_valid ? slot_pc_q[head_q] : last_pc_q;
    pop   = if_valid && if_ready;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    head_d     = head_q;
    tail_d     = tail_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    drop_d     = drop_q;
    done_d     = done_q;
    fetch_pc_d = fetch_pc_q;
    last_pc_d  = if_pc;
    run_d      = 1'b1;
    pc_we      = '0;
    instr_we   = '0;

    if (redirect) begin
      // Flush everything. Each fetch still owed by memory becomes a drop,
      // less any response that arrives this very cycle.
      head_d     = '0;
      tail_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      out_d      = '0;
      done_d     = '0;
      fetch_pc_d = redirect_pc & ~64'h3;
      drop_d     = drop_q + out_q - CW'(imem_rsp_valid && ((drop_q | out_q) != '0));
    end else begin
      if (accept) begin
        pc_we[tail_q] = 1'b1;
        tail_d        = tail_q + 1'b1;
        fetch_pc_d    = fetch_pc_q + 64'd4;
      end
      if (rsp_take) begin
        instr_we[rptr_q] = 1'b1;
        done_d[rptr_q]   = 1'b1;
        rptr_d           = rptr_q + 1'b1;
      end else if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      // A bypassed pop has head == rptr, so this clear overrides the set above.
      if (pop) begin
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
      out_d = out_q + CW'(accept) - CW'(rsp_take);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, whatever the order the statements appear in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      done_q     <= '0;
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
      run_q      <= run_d;
    end
  end

  // NOTE: slot storage is deliberately not reset. The done bits and counters
  // guard every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pc_we[i])    slot_pc_q[i]    <= fetch_pc_q;
      if (instr_we[i]) slot_instr_q[i] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, redirect, imem_req_ready, imem_rsp_valid, if_ready;
  logic [63:0] redirect_pc;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, if_valid;
  logic [63:0] imem_req_addr, if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [63:0] acc_addr[$];
  int          acc_cyc[$];
  logic [63:0] pop_pc[$];
  int          pop_cyc[$];
  int cyc = 0, lat = 1, checks = 0, errors = 0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory: in-order responses, lat cycles after accept.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!reset) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // Scoreboard: expected {pc, instr} pushed at accept, compared at pop.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        exp_q.push_back('{pc: imem_req_addr, instr: instr_of(imem_req_addr)});
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        acc_addr.push_back(imem_req_addr);
        acc_cyc.push_back(cyc);
      end
      if (if_valid && if_ready) begin
        pop_pc.push_back(if_pc);
        pop_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got pc=%h instr=%h, expected no output", if_pc, if_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
      if (redirect) exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset(input logic rr, input logic ir, input int l);
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = rr;
    if_ready = ir;
    lat = l;
    clear_logs();
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic wait_accepts(input int n, input string name);
    for (int k = 0; k < 40 && acc_addr.size() < n; k++) tick();
    if (acc_addr.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d accepts, expected %0d", name, acc_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    #3 reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks += 5;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
    if (if_pc !== 64'h0) begin errors++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
    if (if_instr !== NOP) begin errors++; $display("FAIL rst_if_instr: got %h expected %h", if_instr, NOP); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1, 1);
    repeat (20) tick();
    checks++;
    if (acc_addr.size() < 4 || pop_cyc.size() < 10) begin
      errors++;
      $display("FAIL stream_count: got %0d accepts %0d pops, expected >=4 and >=10",
               acc_addr.size(), pop_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_addr[i] !== 64'(4 * i)) begin
          errors++;
          $display("FAIL stream_addr%0d: got %h expected %h", i, acc_addr[i], 64'(4 * i));
        end
      end
      checks++;
      if (pop_cyc[0] != acc_cyc[0] + 2 - BYP) begin
        errors++;
        $display("FAIL stream_first_latency: got cycle %0d expected %0d", pop_cyc[0], acc_cyc[0] + 2 - BYP);
      end
      for (int k = 1; k < 10; k++) begin
        checks++;
        if (pop_cyc[k] != pop_cyc[0] + k) begin
          errors++;
          $display("FAIL stream_rate%0d: got cycle %0d expected %0d", k, pop_cyc[k], pop_cyc[0] + k);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset(1'b1, 1'b0, 1);
    repeat (12) tick();
    @(negedge clk);
    checks += 2;
    if (acc_addr.size() != 4) begin errors++; $display("FAIL full_accepts: got %0d expected 4", acc_addr.size()); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b expected 0", imem_req_valid); end
    tick();
    if_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (pop_pc.size() < 4 || acc_addr.size() < 5) begin
      errors++;
      $display("FAIL full_drain: got %0d pops %0d accepts, expected >=4 and >=5", pop_pc.size(), acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_pc[i] !== 64'(4 * i)) begin
          errors++;
          $display("FAIL full_pop_pc%0d: got %h expected %h", i, pop_pc[i], 64'(4 * i));
        end
      end
      checks += 2;
      if (acc_addr[4] !== 64'h10) begin errors++; $display("FAIL full_resume_addr: got %h expected 10", acc_addr[4]); end
      if (acc_cyc[4] != pop_cyc[0] + 1) begin
        errors++;
        $display("FAIL full_resume_cycle: got %0d expected %0d", acc_cyc[4], pop_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b1, 3);
    wait_accepts(2, "redir");
    redirect = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b expected 0", imem_req_valid); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks += 3;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_if_valid: got %b expected 0", if_valid); end
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_req_valid: got %b expected 1", imem_req_valid); end
    if (imem_req_addr !== 64'h100) begin errors++; $display("FAIL redir_req_addr: got %h expected 100", imem_req_addr); end
    repeat (15) tick();
    checks++;
    if (pop_pc.size() == 0 || acc_addr.size() < 3) begin
      errors++;
      $display("FAIL redir_progress: got %0d pops %0d accepts, expected >=1 and >=3", pop_pc.size(), acc_addr.size());
    end else begin
      checks += 2;
      if (pop_pc[0] !== 64'h100) begin errors++; $display("FAIL redir_first_pc: got %h expected 100", pop_pc[0]); end
      if (acc_addr[2] !== 64'h100) begin errors++; $display("FAIL redir_accept: got %h expected 100", acc_addr[2]); end
    end
  endtask

  task automatic test_hold();
    do_reset(1'b1, 1'b1, 1);
    wait_accepts(2, "hold");
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b expected 1", k, imem_req_valid); end
      if (imem_req_addr !== 64'h8) begin errors++; $display("FAIL hold_addr%0d: got %h expected 8", k, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (acc_addr.size() < 4) begin
      errors++;
      $display("FAIL hold_count: got %0d accepts expected >=4", acc_addr.size());
    end else begin
      checks += 2;
      if (acc_addr[2] !== 64'h8) begin errors++; $display("FAIL hold_accept8: got %h expected 8", acc_addr[2]); end
      if (acc_addr[3] !== 64'hC) begin errors++; $display("FAIL hold_acceptC: got %h expected c", acc_addr[3]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1, 1);
    repeat (8) tick();
    #1 reset = 1'b0;
    #1;
    checks += 5;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL mid_req_addr: got %h expected 0", imem_req_addr); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_if_valid: got %b expected 0", if_valid); end
    if (if_pc !== 64'h0) begin errors++; $display("FAIL mid_if_pc: got %h expected 0", if_pc); end
    if (if_instr !== NOP) begin errors++; $display("FAIL mid_if_instr: got %h expected %h", if_instr, NOP); end
    clear_logs();
    repeat (2) tick();
    reset = 1'b1;
    wait_accepts(1, "mid");
    checks++;
    if (acc_addr.size() == 0 || acc_addr[0] !== 64'h0) begin
      errors++;
      $display("FAIL mid_first_addr: got %0d accepts, expected first addr 0", acc_addr.size());
    end
  endtask

  task automatic test_latency();
    bit found = 0;
    do_reset(1'b1, 1'b1, 2);
    wait_accepts(1, "lat");
    imem_req_ready = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (imem_rsp_valid) found = 1;
    end
    checks++;
    if (!found || acc_cyc.size() == 0) begin
      errors++;
      $display("FAIL lat_rsp_timeout: got no response, expected one");
    end else begin
      checks += 2;
      if (cyc != acc_cyc[0] + 2) begin errors++; $display("FAIL lat_rsp_cycle: got %0d expected %0d", cyc, acc_cyc[0] + 2); end
      if (if_valid !== 1'(BYP)) begin errors++; $display("FAIL lat_same_cycle: got if_valid=%b expected %0d", if_valid, BYP); end
      tick();
      @(negedge clk);
      checks++;
      if (if_valid !== 1'(1 - BYP)) begin errors++; $display("FAIL lat_next_cycle: got if_valid=%b expected %0d", if_valid, 1 - BYP); end
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_hold();
    test_reset_mid();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
